// File: rtl/alu_share_arbiter_if.sv
// Request, shared-ALU and response signals between the requesters, the shared ALU
// and alu_share_arbiter.
interface alu_share_arbiter_if #(
  parameter int unsigned NREQ  = 3,
  parameter int unsigned WIDTH = 32
);
  logic [NREQ-1:0]       req_valid;
  logic [NREQ-1:0]       req_ready;
  logic [4*NREQ-1:0]     req_ctrl;
  logic [WIDTH*NREQ-1:0] req_a;
  logic [WIDTH*NREQ-1:0] req_b;
  logic [3:0]            alu_ctrl;
  logic [WIDTH-1:0]      alu_a;
  logic [WIDTH-1:0]      alu_b;
  logic [WIDTH-1:0]      alu_result;
  logic                  alu_zero;
  logic [NREQ-1:0]       rsp_valid;
  logic [NREQ-1:0]       rsp_ready;
  logic [WIDTH-1:0]      rsp_result;
  logic                  rsp_zero;
  logic                  rsp_err;
  logic                  busy;

  // Arbiter side.
  modport slave (
    input  req_valid, req_ctrl, req_a, req_b, alu_result, alu_zero, rsp_ready,
    output req_ready, alu_ctrl, alu_a, alu_b, rsp_valid, rsp_result, rsp_zero, rsp_err, busy
  );

  // Requester and ALU side.
  modport master (
    output req_valid, req_ctrl, req_a, req_b, alu_result, alu_zero, rsp_ready,
    input  req_ready, alu_ctrl, alu_a, alu_b, rsp_valid, rsp_result, rsp_zero, rsp_err, busy
  );
endinterface

// File: rtl/alu_share_arbiter.sv
// Round-robin arbiter that shares one combinational ALU between NREQ requesters,
// issuing one registered operation at a time and returning its result on a
// valid/ready response channel.
module alu_share_arbiter #(
  parameter int unsigned NREQ  = 3,
  parameter int unsigned WIDTH = 32
) (
  input logic               clk,
  input logic               reset_n,
  alu_share_arbiter_if.slave bus
);
  localparam int unsigned IDXW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [IDXW-1:0] LAST = IDXW'(NREQ - 1);

  typedef enum logic [1:0] {StIdle, StExec, StResp} state_e;

  state_e           state_q, state_d;
  logic [IDXW-1:0]  ptr_q, owner_q, grant_idx, ptr_next;
  logic             grant_found, grant_ok;
  logic [3:0]       ctrl_q;
  logic [WIDTH-1:0] a_q, b_q, result_q;
  logic             zero_q, err_q;

  logic [3:0]       ctrl_arr [NREQ];
  logic [WIDTH-1:0] a_arr    [NREQ];
  logic [WIDTH-1:0] b_arr    [NREQ];

  for (genvar i = 0; i < NREQ; i++) begin : g_unpack
    assign ctrl_arr[i] = bus.req_ctrl[4*i +: 4];
    assign a_arr[i]    = bus.req_a[WIDTH*i +: WIDTH];
    assign b_arr[i]    = bus.req_b[WIDTH*i +: WIDTH];
  end

  // Search upward from ptr with wrap; first valid requester wins.
  always_comb begin : rr_grant
    logic [IDXW-1:0] idx;
    idx         = ptr_q;
    grant_found = 1'b0;
    grant_idx   = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      if (!grant_found && bus.req_valid[idx]) begin
        grant_found = 1'b1;
        grant_idx   = idx;
      end
      idx = (idx == LAST) ? '0 : idx + 1'b1;
    end
  end

  assign ptr_next = (grant_idx == LAST) ? '0 : grant_idx + 1'b1;
  assign grant_ok = (ctrl_arr[grant_idx] <= 4'd9) || (ctrl_arr[grant_idx] == 4'hF);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= StIdle;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:  if (grant_found) state_d = grant_ok ? StExec : StResp;
      StExec:  state_d = StResp;
      StResp:  if (bus.rsp_ready[owner_q]) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // req_ready is gated by reset so nothing is offered while reset is held.
  always_comb begin
    bus.req_ready = '0;
    bus.rsp_valid = '0;
    bus.busy      = 1'b0;
    case (state_q)
      StIdle:  if (reset_n && grant_found) bus.req_ready[grant_idx] = 1'b1;
      StExec:  bus.busy = 1'b1;
      StResp: begin
        bus.busy               = 1'b1;
        bus.rsp_valid[owner_q] = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ptr_q    <= '0;
      owner_q  <= '0;
      ctrl_q   <= '0;
      a_q      <= '0;
      b_q      <= '0;
      result_q <= '0;
      zero_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          if (grant_found) begin
            ctrl_q  <= ctrl_arr[grant_idx];
            a_q     <= a_arr[grant_idx];
            b_q     <= b_arr[grant_idx];
            owner_q <= grant_idx;
            ptr_q   <= ptr_next;
            if (!grant_ok) begin
              result_q <= '0;
              zero_q   <= 1'b0;
              err_q    <= 1'b1;
            end
          end
        end
        StExec: begin
          result_q <= bus.alu_result;
          zero_q   <= bus.alu_zero;
          err_q    <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign bus.alu_ctrl   = ctrl_q;
  assign bus.alu_a      = a_q;
  assign bus.alu_b      = b_q;
  assign bus.rsp_result = result_q;
  assign bus.rsp_zero   = zero_q;
  assign bus.rsp_err    = err_q;
endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed bench for alu_share_arbiter: the bench plays the requesters and the
// shared ALU, and compares against hand-computed expectations.
module tb_alu_share_arbiter;
  localparam int unsigned NREQ  = 3;
  localparam int unsigned WIDTH = 32;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  alu_share_arbiter_if #(.NREQ(NREQ), .WIDTH(WIDTH)) bus ();

  alu_share_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  // Reference ALU driven by the arbiter's registered outputs.
  always_comb begin
    bus.alu_result = '0;
    case (bus.alu_ctrl)
      4'd0:  bus.alu_result = bus.alu_a + bus.alu_b;
      4'd1:  bus.alu_result = bus.alu_a - bus.alu_b;
      4'd2:  bus.alu_result = bus.alu_a & bus.alu_b;
      4'd3:  bus.alu_result = bus.alu_a | bus.alu_b;
      4'd4:  bus.alu_result = bus.alu_a ^ bus.alu_b;
      4'd5:  bus.alu_result = {31'd0, $signed(bus.alu_a) < $signed(bus.alu_b)};
      4'd6:  bus.alu_result = bus.alu_a << bus.alu_b[4:0];
      4'd7:  bus.alu_result = bus.alu_a >> bus.alu_b[4:0];
      4'd8:  bus.alu_result = $unsigned($signed(bus.alu_a) >>> bus.alu_b[4:0]);
      4'd9:  bus.alu_result = {31'd0, bus.alu_a < bus.alu_b};
      4'd15: bus.alu_result = bus.alu_b;
      default: bus.alu_result = '0;
    endcase
    bus.alu_zero = (bus.alu_result == '0);
  end

  typedef struct {
    int unsigned req;
    logic [3:0]  ctrl;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic        zero;
    logic        err;
  } vec_t;

  vec_t vecs [8];
  int   checks   = 0;
  int   failures = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [2:0] oh(input int unsigned i);
    return 3'(1 << i);
  endfunction

  task automatic set_req(input int unsigned i, input logic [3:0] c, input logic [31:0] a,
                         input logic [31:0] b);
    bus.req_ctrl[4*i +: 4]          = c;
    bus.req_a[WIDTH*i +: WIDTH]     = a;
    bus.req_b[WIDTH*i +: WIDTH]     = b;
  endtask

  // Called at a negedge; returns at a negedge+1 where req_ready is nonzero.
  task automatic wait_grant(output int waits, output bit ok);
    waits = 0;
    ok    = 1'b0;
    while (waits < 20) begin
      #1;
      if (bus.req_ready != '0) begin
        ok = 1'b1;
        return;
      end
      @(negedge clk);
      waits++;
    end
    check("grant_timeout", 64'd1, 64'd0);
  endtask

  task automatic do_op(input vec_t v);
    int waits;
    bit ok;
    set_req(v.req, v.ctrl, v.a, v.b);
    bus.req_valid = oh(v.req);
    wait_grant(waits, ok);
    if (!ok) begin
      bus.req_valid = '0;
      return;
    end
    check("op_grant", bus.req_ready, oh(v.req));
    @(negedge clk);
    bus.req_valid = '0;
    #1;
    check("op_alu_ctrl", bus.alu_ctrl, v.ctrl);
    check("op_alu_a", bus.alu_a, v.a);
    check("op_alu_b", bus.alu_b, v.b);
    check("op_busy", bus.busy, 1'b1);
    if (!v.err) begin
      check("op_rsp_early", bus.rsp_valid, 3'b000);
      @(negedge clk);
      #1;
    end
    check("op_rsp_valid", bus.rsp_valid, oh(v.req));
    check("op_result", bus.rsp_result, v.res);
    check("op_zero", bus.rsp_zero, v.zero);
    check("op_err", bus.rsp_err, v.err);
    @(negedge clk);
    #1;
    check("op_idle", bus.busy, 1'b0);
  endtask

  initial begin
    int   waits;
    bit   ok;
    logic [2:0] seen;

    vecs[0] = '{req: 1, ctrl: 4'b0001, a: 32'd10,      b: 32'd3,      res: 32'd7,     zero: 0, err: 0};
    vecs[1] = '{req: 0, ctrl: 4'b0000, a: 32'd5,       b: 32'd7,      res: 32'd12,    zero: 0, err: 0};
    vecs[2] = '{req: 2, ctrl: 4'b0010, a: 32'hF0F0,    b: 32'h0FF0,   res: 32'h00F0,  zero: 0, err: 0};
    vecs[3] = '{req: 1, ctrl: 4'b0001, a: 32'd9,       b: 32'd9,      res: 32'd0,     zero: 1, err: 0};
    vecs[4] = '{req: 2, ctrl: 4'b1100, a: 32'd4,       b: 32'd5,      res: 32'd0,     zero: 0, err: 1};
    vecs[5] = '{req: 0, ctrl: 4'b1001, a: 32'd1,       b: 32'd2,      res: 32'd1,     zero: 0, err: 0};
    vecs[6] = '{req: 2, ctrl: 4'b1010, a: 32'd6,       b: 32'd6,      res: 32'd0,     zero: 0, err: 1};
    vecs[7] = '{req: 1, ctrl: 4'b1111, a: 32'd0,       b: 32'h1234,   res: 32'h1234,  zero: 0, err: 0};

    // Reset with random inputs: every output must read zero.
    reset_n       = 1'b0;
    bus.req_valid = 3'($urandom);
    bus.rsp_ready = 3'($urandom);
    bus.req_ctrl  = 12'($urandom);
    bus.req_a     = {$urandom, $urandom, $urandom};
    bus.req_b     = {$urandom, $urandom, $urandom};
    repeat (3) @(negedge clk);
    #1;
    check("rst_req_ready", bus.req_ready, 3'b000);
    check("rst_rsp_valid", bus.rsp_valid, 3'b000);
    check("rst_busy", bus.busy, 1'b0);
    check("rst_alu", {bus.alu_ctrl, bus.alu_a, bus.alu_b}, '0);
    check("rst_rsp", {bus.rsp_result, bus.rsp_zero, bus.rsp_err}, '0);
    @(negedge clk);
    bus.req_valid = 3'b111;
    reset_n       = 1'b1;
    #1;
    check("rst_rel_ptr0", bus.req_ready, 3'b001);
    bus.req_valid = 3'b110;
    #1;
    check("rst_rel_skip", bus.req_ready, 3'b010);
    bus.req_valid = '0;
    @(negedge clk);

    // Round-robin with all requesters held valid.
    for (int i = 0; i < 3; i++) set_req(i, 4'b0000, 32'(100 * (i + 1)), 32'(i + 1));
    bus.rsp_ready = 3'b111;
    bus.req_valid = 3'b111;
    for (int n = 0; n < 4; n++) begin
      wait_grant(waits, ok);
      if (!ok) break;
      check("rr_grant", bus.req_ready, oh(n % 3));
      if (n > 0) check("rr_spacing", waits, 0);
      @(negedge clk);
      @(negedge clk);
      #1;
      check("rr_rsp_valid", bus.rsp_valid, oh(n % 3));
      check("rr_result", bus.rsp_result, 32'(101 * ((n % 3) + 1)));
      if (n == 3) bus.req_valid = '0;
      @(negedge clk);
    end
    bus.req_valid = '0;

    // Backpressure on a zero result while another requester waits.
    bus.rsp_ready = 3'b000;
    set_req(1, 4'b0001, 32'h55, 32'h55);
    set_req(2, 4'b0000, 32'd1, 32'd2);
    bus.req_valid = 3'b110;
    wait_grant(waits, ok);
    check("bp_grant", bus.req_ready, 3'b010);
    @(negedge clk);
    bus.req_valid = 3'b100;
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      bus.rsp_ready = 3'b101;
      #1;
      check("bp_valid", bus.rsp_valid, 3'b010);
      check("bp_result", bus.rsp_result, 32'd0);
      check("bp_zero", bus.rsp_zero, 1'b1);
      check("bp_no_grant", bus.req_ready, 3'b000);
      @(negedge clk);
    end
    bus.rsp_ready = 3'b010;
    @(negedge clk);
    #1;
    check("bp_next_grant", bus.req_ready, 3'b100);
    bus.rsp_ready = 3'b111;
    @(negedge clk);
    bus.req_valid = '0;
    @(negedge clk);
    #1;
    check("bp_next_valid", bus.rsp_valid, 3'b100);
    check("bp_next_result", bus.rsp_result, 32'd3);
    @(negedge clk);

    for (int i = 0; i < 8; i++) do_op(vecs[i]);

    // Reset during EXEC abandons the op.
    @(negedge clk);
    set_req(1, 4'b0000, 32'd7, 32'd8);
    bus.req_valid = 3'b010;
    wait_grant(waits, ok);
    @(negedge clk);
    #1;
    check("mid_exec_busy", bus.busy, 1'b1);
    reset_n       = 1'b0;
    bus.req_valid = '0;
    #1;
    check("mid_rst_busy", bus.busy, 1'b0);
    check("mid_rst_valid", bus.rsp_valid, 3'b000);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    seen    = '0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      #1;
      seen |= bus.rsp_valid;
    end
    check("mid_rst_no_rsp", seen, 3'b000);
    bus.req_valid = 3'b111;
    #1;
    check("mid_rst_ptr0", bus.req_ready, 3'b001);
    bus.req_valid = '0;
    @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
